sd_sector_buffer: RTL and testbench
===================================

// Module: sd_sector_buffer
// PURPOSE
// - 512-byte sector buffer between the CPU bus and sd_controller.
// - CPU fills or reads the buffer, then issues a sector read/write by LBA.
// - Block drives sd_controller's rd/wr/address/din handshakes and captures dout/byte_available.
// - Reports busy/done/error to the CPU.
// PARAMETERS
// - TIMEOUT_CYCLES  default 50_000_000  max clk cycles per command (request + data) before error abort
// PORTS
// - clk               in   1   system clock (25 MHz, same as sd_controller)
// - reset             in   1   synchronous, active-high reset
// - cmd_rd            in   1   1-cycle pulse: read sector lba into buffer
// - cmd_wr            in   1   1-cycle pulse: write buffer to sector lba
// - lba               in   23  sector number, latched when a command is accepted
// - busy              out  1   command in progress
// - done              out  1   1-cycle pulse: command finished (check error)
// - error             out  1   last command failed (timeout or byte count != 512)
// - buf_addr          in   9   CPU buffer byte address
// - buf_wdata         in   8   CPU write data
// - buf_we            in   1   CPU write strobe
// - buf_rdata         out  8   buffer[buf_addr], registered, 1-cycle latency
// - sd_ready          in   1   sd_controller ready
// - sd_rd             out  1   to sd_controller rd
// - sd_wr             out  1   to sd_controller wr
// - sd_address        out  32  {lba_q, 9'b0}, byte address of the sector
// - sd_dout           in   8   from sd_controller dout
// - sd_byte_available in   1   from sd_controller byte_available
// - sd_din            out  8   to sd_controller din, registered
// - sd_ready_for_next in   1   from sd_controller ready_for_next_byte
// BEHAVIOUR
// - Reset values
//   - State S_IDLE.
//   - busy=0, done=0, error=0, sd_rd=0, sd_wr=0, sd_address=0, sd_din=0, buf_rdata=0.
//   - Pointer and timeout counter cleared.
//   - Buffer RAM contents are not cleared.
// - CPU port
//   - buf_rdata = mem[buf_addr] one cycle after buf_addr is presented.
//   - buf_we writes mem[buf_addr] only while busy=0; writes while busy=1 are dropped.
//   - Reads while busy=1 return the current RAM contents.
// - Command accept (S_IDLE only)
//   - cmd_rd has priority over cmd_wr.
//   - On accept: latch lba, clear error, ptr=0, tmo=0, busy=1.
//   - Commands arriving while busy=1 are ignored.
// - S_RD_REQ: sd_rd=1 while sd_ready=1; sd_ready falls -> sd_rd=0, go to S_RD_DATA.
// - S_RD_DATA
//   - On each rising edge of sd_byte_available (registered edge detect) with ptr<512: mem[ptr]<=sd_dout, ptr++.
//   - Edges after ptr reaches 512 are dropped.
//   - sd_ready rises -> S_IDLE, done=1, error=(ptr!=512).
// - S_WR_REQ
//   - On entry, sd_din<=mem[0].
//   - sd_wr=1 while sd_ready=1; sd_ready falls -> sd_wr=0, go to S_WR_DATA, ptr=0, first_seen=0.
// - S_WR_DATA
//   - First rising edge of sd_ready_for_next is the command phase: ignore it, set first_seen=1.
//   - Each later rising edge means byte ptr was consumed: ptr++, then sd_din<=mem[ptr+1]. Valid well before the next sample (>=16 clks).
//   - ptr saturates at 512; sd_din beyond the last byte is don't-care.
//   - sd_ready rises -> S_IDLE, done=1, error=(ptr!=512).
// - Timeout
//   - tmo increments every cycle in REQ/DATA states.
//   - tmo==TIMEOUT_CYCLES-1 -> drop sd_rd/sd_wr, S_IDLE, done=1, error=1.
// - Edge detectors are seeded with the current input value on command accept, so a level already high is not counted.
// - done is high exactly 1 cycle; error holds until the next accepted command.
// - Reset mid-command: immediate S_IDLE, all outputs to reset values, no done pulse.
//   - sd_controller is not reset by this block.
// TESTING
// - Read, lba=5: sd_rd seen with sd_address=0x0000_0A00; 512 byte_available pulses of dout=i&0xFF -> done, error=0, buf_rdata[addr]=addr&0xFF.
// - Write: CPU fills mem[i]=~i, cmd_wr -> sd_din presents 0xFF,0xFE,0xFD... at successive samples; first rfnb rise ignored; done, error=0.
// - Short read: 300 pulses then sd_ready=1 -> done, error=1; next good read clears error.
// - Timeout, TIMEOUT_CYCLES=1000: sd_ready held low after request -> done+error at cycle 1000, busy=0.
// - cmd_rd and cmd_wr same cycle -> read performed; cmd_wr during busy ignored; buf_we during busy leaves RAM unchanged.
// - Reset asserted at byte 100 of a read -> next cycle busy=0, sd_rd=0, done=0; bytes 0..99 retained in RAM.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// Purpose : 512-byte sector buffer bridging a CPU byte port and sd_controller; runs sector read/write by LBA.
// Latency : buf_rdata 1 clk after buf_addr; command completion signalled by a 1-clk done pulse.
// Flow    : CPU writes and commands are dropped while busy; sd side paced by sd_ready / byte_available / ready_for_next.
// Ports   : clk, reset (sync, active-high)
//           CPU  : cmd_rd, cmd_wr, lba[22:0], busy, done, error, buf_addr[8:0], buf_wdata, buf_we, buf_rdata
//           SD   : sd_ready, sd_rd, sd_wr, sd_address[31:0], sd_dout, sd_byte_available, sd_din, sd_ready_for_next
module sd_sector_buffer #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_rd,
   input  logic        cmd_wr,
   input  logic [22:0] lba,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic [8:0]  buf_addr,
   input  logic [7:0]  buf_wdata,
   input  logic        buf_we,
   output logic [7:0]  buf_rdata,
   input  logic        sd_ready,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic [31:0] sd_address,
   input  logic [7:0]  sd_dout,
   input  logic        sd_byte_available,
   output logic [7:0]  sd_din,
   input  logic        sd_ready_for_next
);

   localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [9:0]  SECTOR_LEN = 10'd512;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_DATA
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  mem [0:511];
   logic [22:0] lba_q;
   logic [9:0]  ptr;           // bytes transferred, saturates at 512
   logic [31:0] tmo;
   logic        bav_q;
   logic        rfn_q;
   logic        first_seen;    // command-phase ready_for_next edge already skipped

   logic        bav_rise;
   logic        rfn_rise;
   logic        tmo_hit;
   logic        accept;
   logic        finish;
   logic        ptr_full;

   // ------------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      bav_rise   = sd_byte_available & ~bav_q;
      rfn_rise   = sd_ready_for_next & ~rfn_q;
      ptr_full   = (ptr == SECTOR_LEN);
      tmo_hit    = (state != S_IDLE) && (tmo == TMO_LAST);
      accept     = (state == S_IDLE) && (cmd_rd || cmd_wr);
      state_nxt  = state;
      finish     = 1'b0;

      case (state)
         S_IDLE: begin
            if (cmd_rd)      state_nxt = S_RD_REQ;
            else if (cmd_wr) state_nxt = S_WR_REQ;
         end
         S_RD_REQ:  if (!sd_ready) state_nxt = S_RD_DATA;
         S_RD_DATA: if (sd_ready) begin state_nxt = S_IDLE; finish = 1'b1; end
         S_WR_REQ:  if (!sd_ready) state_nxt = S_WR_DATA;
         S_WR_DATA: if (sd_ready) begin state_nxt = S_IDLE; finish = 1'b1; end
         default:   state_nxt = S_IDLE;
      endcase

      // A stuck controller aborts the command regardless of phase.
      if (tmo_hit) begin
         state_nxt = S_IDLE;
         finish    = 1'b1;
      end

      busy       = (state != S_IDLE);
      sd_rd      = (state == S_RD_REQ);
      sd_wr      = (state == S_WR_REQ);
      sd_address = {lba_q, 9'b0};
   end

   // ------------------------------------------------------------------
   // State, pointers, status and registered data outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         lba_q      <= '0;
         ptr        <= '0;
         tmo        <= '0;
         bav_q      <= 1'b0;
         rfn_q      <= 1'b0;
         first_seen <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         sd_din     <= '0;
         buf_rdata  <= '0;
      end else begin
         state     <= state_nxt;
         // Sampled every cycle, so a level already high at accept never looks like an edge.
         bav_q     <= sd_byte_available;
         rfn_q     <= sd_ready_for_next;
         done      <= finish;
         buf_rdata <= mem[buf_addr];

         if (accept) begin
            lba_q <= lba;
            error <= 1'b0;
            ptr   <= '0;
            tmo   <= '0;
            if (!cmd_rd) sd_din <= mem[0];
         end else if (state != S_IDLE) begin
            tmo <= tmo + 32'd1;
         end

         if (finish) error <= tmo_hit | ~ptr_full;

         if (state == S_RD_DATA && bav_rise && !ptr_full) ptr <= ptr + 10'd1;

         if (state == S_WR_REQ && !sd_ready) begin
            ptr        <= '0;
            first_seen <= 1'b0;
         end

         // sd_din always shows the byte at ptr; the first edge belongs to the command phase.
         if (state == S_WR_DATA && rfn_rise) begin
            if (!first_seen) begin
               first_seen <= 1'b1;
            end else if (!ptr_full) begin
               ptr    <= ptr + 10'd1;
               sd_din <= mem[ptr[8:0] + 9'd1];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Buffer RAM: single write port shared by the CPU (idle only) and read capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == S_IDLE && buf_we)
            mem[buf_addr] <= buf_wdata;
         else if (state == S_RD_DATA && bav_rise && !ptr_full)
            mem[ptr[8:0]] <= sd_dout;
      end
   end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Purpose : self-checking bench for sd_sector_buffer with an sd_controller stand-in and a RAM reference model.
// Latency : expectations queued at stimulus time, popped by a negedge monitor on done / read-back / din sample.
// Flow    : sd side driven by tasks; every wait on the DUT is cycle-bounded.
module tb_sd_sector_buffer;

   localparam int TMO = 5000;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_rd, cmd_wr;
   logic [22:0] lba;
   logic        busy, done, error;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_wdata;
   logic        buf_we;
   logic [7:0]  buf_rdata;
   logic        sd_ready, sd_rd, sd_wr;
   logic [31:0] sd_address;
   logic [7:0]  sd_dout;
   logic        sd_byte_available;
   logic [7:0]  sd_din;
   logic        sd_ready_for_next;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  model_mem [512];
   logic [7:0]  exp_rd_q  [$];
   logic [7:0]  exp_din_q [$];
   bit          exp_err_q [$];
   bit          rd_issue;
   bit          rd_pend;
   bit          din_smp;

   sd_sector_buffer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_rd            (cmd_rd),
      .cmd_wr            (cmd_wr),
      .lba               (lba),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .buf_addr          (buf_addr),
      .buf_wdata         (buf_wdata),
      .buf_we            (buf_we),
      .buf_rdata         (buf_rdata),
      .sd_ready          (sd_ready),
      .sd_rd             (sd_rd),
      .sd_wr             (sd_wr),
      .sd_address        (sd_address),
      .sd_dout           (sd_dout),
      .sd_byte_available (sd_byte_available),
      .sd_din            (sd_din),
      .sd_ready_for_next (sd_ready_for_next)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) rd_pend <= rd_issue;

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (done) begin
            if (exp_err_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               chk("done_error", 32'(error), 32'(exp_err_q.pop_front()));
               chk("done_busy", 32'(busy), 32'd0);
            end
         end
         if (rd_pend) begin
            if (exp_rd_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else chk("buf_rdata", 32'(buf_rdata), 32'(exp_rd_q.pop_front()));
         end
         if (din_smp) begin
            if (exp_din_q.size() == 0) chk("din_underflow", 32'd1, 32'd0);
            else chk("sd_din", 32'(sd_din), 32'(exp_din_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string name);
      int w = 0;
      while (busy && w < 200) begin tick(); w++; end
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic readback_all();
      for (int a = 0; a < 512; a++) begin
         tick();
         buf_addr = 9'(a);
         rd_issue = 1'b1;
         exp_rd_q.push_back(model_mem[a]);
      end
      tick();
      rd_issue = 1'b0;
      tick(2);
   endtask

   task automatic fill_all(input bit rnd);
      for (int a = 0; a < 512; a++) begin
         tick();
         buf_addr  = 9'(a);
         buf_wdata = rnd ? 8'($urandom) : ~8'(a);
         buf_we    = 1'b1;
         model_mem[a] = buf_wdata;
      end
      tick();
      buf_we = 1'b0;
   endtask

   // Sector read: n byte pulses; poke adds a cmd_wr and a CPU write while busy.
   task automatic do_read(input logic [22:0] l, input int n, input bit rnd, input bit both, input bit poke);
      int  w = 0;
      logic [7:0] d;
      logic [8:0] poke_addr = 9'd400;
      tick();
      lba    = l;
      cmd_rd = 1'b1;
      cmd_wr = both;
      exp_err_q.push_back(n != 512 && n < 512);
      tick();
      cmd_rd = 1'b0;
      cmd_wr = 1'b0;
      chk("err_clr_on_accept", 32'(error), 32'd0);
      while (!sd_rd && w < 50) begin tick(); w++; end
      chk("sd_rd_seen", 32'(sd_rd), 32'd1);
      chk("rd_no_sd_wr", 32'(sd_wr), 32'd0);
      chk("rd_address", sd_address, {l, 9'b0});
      sd_ready = 1'b0;
      tick();
      chk("sd_rd_drop", 32'(sd_rd), 32'd0);
      tick();
      for (int i = 0; i < n; i++) begin
         d = rnd ? 8'($urandom) : 8'(i);
         sd_dout = d;
         sd_byte_available = 1'b1;
         if (i < 512) model_mem[i] = d;
         if (poke && i == 10) cmd_wr = 1'b1;
         if (poke && i == 20) begin
            buf_addr  = poke_addr;
            buf_wdata = model_mem[poke_addr] ^ 8'hFF;
            buf_we    = 1'b1;
         end
         tick();
         cmd_wr = 1'b0;
         buf_we = 1'b0;
         sd_byte_available = 1'b0;
         sd_dout = 8'($urandom);
         if (poke && i == 10) chk("cmd_wr_busy_ignored", 32'(sd_wr), 32'd0);
         tick();
      end
      sd_ready = 1'b1;
      wait_idle("read_finish");
   endtask

   // Sector write: the controller consumes n bytes after a command-phase edge.
   task automatic do_write(input logic [22:0] l, input int n);
      int w = 0;
      for (int k = 0; k < n; k++) exp_din_q.push_back(model_mem[k]);
      tick();
      lba    = l;
      cmd_wr = 1'b1;
      exp_err_q.push_back(n != 512);
      tick();
      cmd_wr = 1'b0;
      while (!sd_wr && w < 50) begin tick(); w++; end
      chk("sd_wr_seen", 32'(sd_wr), 32'd1);
      chk("wr_address", sd_address, {l, 9'b0});
      sd_ready = 1'b0;
      tick(3);
      sd_ready_for_next = 1'b1;
      tick(2);
      sd_ready_for_next = 1'b0;
      tick(2);
      for (int k = 0; k < n; k++) begin
         sd_ready_for_next = 1'b1;
         din_smp = 1'b1;
         tick();
         din_smp = 1'b0;
         tick();
         sd_ready_for_next = 1'b0;
         tick(3);
      end
      sd_ready = 1'b1;
      wait_idle("write_finish");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cnt;
      reset = 1'b1;
      cmd_rd = 1'b0; cmd_wr = 1'b0; lba = '0;
      buf_addr = '0; buf_wdata = '0; buf_we = 1'b0;
      sd_ready = 1'b1; sd_dout = '0; sd_byte_available = 1'b0; sd_ready_for_next = 1'b0;
      rd_issue = 1'b0; din_smp = 1'b0;
      tick(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_sd_wr", 32'(sd_wr), 32'd0);
      chk("rst_address", sd_address, 32'd0);
      chk("rst_sd_din", 32'(sd_din), 32'd0);
      chk("rst_rdata", 32'(buf_rdata), 32'd0);
      reset = 1'b0;
      tick(2);

      // Full read of sector 5, counting pattern.
      do_read(23'd5, 512, 1'b0, 1'b0, 1'b0);
      readback_all();

      // CPU fills ~i then writes it out.
      fill_all(1'b0);
      do_write(23'($urandom), 512);

      // Short read with interference while busy, error must persist until next command.
      do_read(23'($urandom), 300, 1'b1, 1'b0, 1'b1);
      tick(5);
      chk("error_holds", 32'(error), 32'd1);
      readback_all();

      // Simultaneous commands: read wins, and a good read clears the error.
      do_read(23'($urandom), 512, 1'b1, 1'b1, 1'b0);
      chk("error_cleared", 32'(error), 32'd0);

      // Extra byte pulses beyond the sector are dropped.
      do_read(23'($urandom), 520, 1'b1, 1'b0, 1'b0);
      readback_all();

      // Random fill, short write.
      fill_all(1'b1);
      do_write(23'($urandom), 200);

      // Timeout: controller never comes back.
      tick();
      cmd_rd = 1'b1;
      exp_err_q.push_back(1'b1);
      tick();
      cmd_rd = 1'b0;
      sd_ready = 1'b0;
      cnt = 0;
      while (!done && cnt < TMO + 50) begin tick(); cnt++; end
      chk("tmo_cycles", 32'(cnt), 32'(TMO));
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_sd_rd", 32'(sd_rd), 32'd0);
      sd_ready = 1'b1;
      tick(3);

      // Reset at byte 100 of a read.
      tick();
      lba = 23'($urandom);
      cmd_rd = 1'b1;
      tick();
      cmd_rd = 1'b0;
      sd_ready = 1'b0;
      tick(2);
      for (int i = 0; i < 100; i++) begin
         sd_dout = 8'($urandom);
         sd_byte_available = 1'b1;
         model_mem[i] = sd_dout;
         tick();
         sd_byte_available = 1'b0;
         tick();
      end
      reset = 1'b1;
      tick();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sd_rd", 32'(sd_rd), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      sd_ready = 1'b1;
      tick(3);
      readback_all();

      tick(5);
      chk("err_q_empty", 32'(exp_err_q.size()), 32'd0);
      chk("din_q_empty", 32'(exp_din_q.size()), 32'd0);
      chk("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
